// File: rtl/comando_vai_vem.sv
// Movement sequencer for a position counter. It latches a target (or runs a sweep)
// and issues paced one-cycle vai/vem step pulses based on the fed-back position.
module comando_vai_vem #(
    parameter int M = 100,
    parameter int N = 7,
    parameter int T = 50
) (
    input  logic         clock,
    input  logic         zera_as_n,
    input  logic         inicia,
    input  logic         modo,
    input  logic         para,
    input  logic [N-1:0] alvo,
    input  logic [N-1:0] pos,
    output logic         vai,
    output logic         vem,
    output logic         enable_mov,
    output logic         ocupado,
    output logic         pronto
);

    localparam int PW = $clog2(T);
    localparam logic [N-1:0]  TOPO    = N'(M - 1);
    localparam logic [PW-1:0] PRE_FIM = PW'(T - 1);

    typedef enum logic [2:0] {
        OCIOSO,
        COMPARA,
        ESPERA_TICK,
        PASSO,
        ASSENTA,
        CONCLUI
    } estado_t;

    estado_t       estado_reg;
    logic [PW-1:0] presc_reg;
    logic [N-1:0]  alvo_reg;
    logic          modo_reg;
    logic          dir_reg;

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            estado_reg <= OCIOSO;
            presc_reg  <= '0;
            alvo_reg   <= '0;
            modo_reg   <= 1'b0;
            dir_reg    <= 1'b1;
            vai        <= 1'b0;
            vem        <= 1'b0;
            enable_mov <= 1'b0;
            ocupado    <= 1'b0;
            pronto     <= 1'b0;
        end else begin
            vai    <= 1'b0;
            vem    <= 1'b0;
            pronto <= 1'b0;
            // A stop request pre-empts everything, including a pending step pulse.
            if (para && estado_reg != OCIOSO) begin
                estado_reg <= OCIOSO;
                enable_mov <= 1'b0;
                ocupado    <= 1'b0;
            end else begin
                case (estado_reg)
                    OCIOSO: begin
                        if (inicia && !para) begin
                            alvo_reg   <= (alvo > TOPO) ? TOPO : alvo;
                            modo_reg   <= modo;
                            presc_reg  <= '0;
                            estado_reg <= COMPARA;
                            enable_mov <= 1'b1;
                            ocupado    <= 1'b1;
                        end
                    end
                    COMPARA: begin
                        // The compare cycle is the first tick of the step period, so
                        // COMPARA plus ESPERA_TICK together last exactly T cycles.
                        presc_reg <= presc_reg + 1'b1;
                        if (!modo_reg && pos == alvo_reg) begin
                            estado_reg <= CONCLUI;
                            enable_mov <= 1'b0;
                            pronto     <= 1'b1;
                        end else begin
                            if (!modo_reg) begin
                                dir_reg <= (alvo_reg > pos);
                            end else if (pos == TOPO) begin
                                dir_reg <= 1'b0;
                            end else if (pos == '0) begin
                                dir_reg <= 1'b1;
                            end
                            estado_reg <= ESPERA_TICK;
                        end
                    end
                    ESPERA_TICK: begin
                        if (presc_reg == PRE_FIM) begin
                            presc_reg  <= '0;
                            estado_reg <= PASSO;
                            vai        <= dir_reg;
                            vem        <= !dir_reg;
                        end else begin
                            presc_reg <= presc_reg + 1'b1;
                        end
                    end
                    PASSO: begin
                        estado_reg <= ASSENTA;
                    end
                    ASSENTA: begin
                        // One idle cycle so the counter's new position is visible.
                        presc_reg  <= '0;
                        estado_reg <= COMPARA;
                    end
                    CONCLUI: begin
                        estado_reg <= OCIOSO;
                        ocupado    <= 1'b0;
                    end
                    default: begin
                        estado_reg <= OCIOSO;
                        enable_mov <= 1'b0;
                        ocupado    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_comando_vai_vem.sv
// Bench for comando_vai_vem with an attached saturating position counter; expected
// pulse schedules come from the step-timing rules computed per transaction.
module tb_comando_vai_vem;

    localparam int M    = 100;
    localparam int N    = 7;
    localparam int T    = 4;
    localparam int P    = T + 2;
    localparam int LMAX = 1024;
    localparam int BIG  = 100000;
    localparam logic [N-1:0] TOPO = 7'(M - 1);

    logic         clock = 1'b0;
    logic         zera_as_n;
    logic         inicia;
    logic         modo;
    logic         para;
    logic [N-1:0] alvo;
    logic [N-1:0] pos;
    logic         vai;
    logic         vem;
    logic         enable_mov;
    logic         ocupado;
    logic         pronto;

    logic         load;
    logic [N-1:0] load_val;

    int n_tests = 0;
    int n_fail  = 0;
    int n_move  = 0;
    bit dir_m;

    bit e_vai  [LMAX];
    bit e_vem  [LMAX];
    bit e_pr   [LMAX];
    bit e_busy [LMAX];
    bit e_en   [LMAX];

    always #5 clock = ~clock;

    comando_vai_vem #(.M(M), .N(N), .T(T)) dut (
        .clock      (clock),
        .zera_as_n  (zera_as_n),
        .inicia     (inicia),
        .modo       (modo),
        .para       (para),
        .alvo       (alvo),
        .pos        (pos),
        .vai        (vai),
        .vem        (vem),
        .enable_mov (enable_mov),
        .ocupado    (ocupado),
        .pronto     (pronto)
    );

    // Position counter driven by the sequencer (not reset by zera_as_n).
    always @(posedge clock) begin
        if (load)
            pos <= load_val;
        else if (vai && !vem && pos < TOPO)
            pos <= pos + 7'd1;
        else if (vem && !vai && pos > 7'd0)
            pos <= pos - 7'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_move(input int start, input int a, input bit md, input int cp,
                            input int glitch_in);
        int p, t, k, cc, pc, fin, len, npulse, glitch, p0;
        for (int i = 0; i < LMAX; i++) begin
            e_vai[i] = 0; e_vem[i] = 0; e_pr[i] = 0; e_busy[i] = 0; e_en[i] = 0;
        end
        if (start >= 0) begin
            load = 1'b1; load_val = 7'(start);
            @(posedge clock); #1;
            load = 1'b0;
        end
        p = int'(pos);
        p0 = p;
        t = (a > M - 1) ? M - 1 : a;
        npulse = 0;
        fin = 0;
        k = 0;
        // Schedule: compare at 1+k*P, pulse T cycles later; para at cycle cp
        // cancels everything scheduled after cp.
        forever begin
            cc = 1 + k * P;
            if (cc > cp) begin fin = cp; break; end
            e_busy[cc] = 1; e_en[cc] = 1;
            if (cc == cp) begin fin = cp; break; end
            if (!md && p == t) begin
                e_busy[cc+1] = 1; e_pr[cc+1] = 1; fin = cc + 1;
                break;
            end
            if (!md) dir_m = (t > p);
            else if (p == M - 1) dir_m = 0;
            else if (p == 0) dir_m = 1;
            for (int x = cc + 1; x <= cc + T + 1; x++)
                if (x <= cp) begin e_busy[x] = 1; e_en[x] = 1; end
            pc = cc + T;
            if (pc <= cp) begin
                if (dir_m) begin e_vai[pc] = 1; p++; end
                else begin e_vem[pc] = 1; p--; end
                npulse++;
            end
            if (cp <= cc + T + 1) begin fin = cp; break; end
            k++;
        end
        len = fin + 3;
        glitch = (glitch_in > fin) ? 0 : glitch_in;
        for (int r = 0; r <= len; r++) begin
            if (r == 0) begin
                inicia = 1'b1; alvo = 7'(a); modo = md; para = 1'b0;
            end else begin
                inicia = (r == glitch);
                if (r == glitch) begin
                    alvo = 7'($urandom_range(0, 127));
                    modo = 1'($urandom_range(0, 1));
                end
                para = (r == cp);
            end
            @(negedge clock);
            chk($sformatf("vai[m%0d r%0d]", n_move, r), vai, e_vai[r]);
            chk($sformatf("vem[m%0d r%0d]", n_move, r), vem, e_vem[r]);
            chk($sformatf("pronto[m%0d r%0d]", n_move, r), pronto, e_pr[r]);
            chk($sformatf("ocupado[m%0d r%0d]", n_move, r), ocupado, e_busy[r]);
            chk($sformatf("enable_mov[m%0d r%0d]", n_move, r), enable_mov, e_en[r]);
            chk($sformatf("invariant[m%0d r%0d]", n_move, r),
                (vai & vem) | (vai & (pos == TOPO)) | (vem & (pos == 7'd0)), 0);
            @(posedge clock); #1;
        end
        inicia = 1'b0; para = 1'b0;
        chk($sformatf("pos_final[m%0d]", n_move), pos, p);
        $display("[TB] move %0d: start=%0d alvo=%0d modo=%0d para@%0d glitch@%0d -> pulses=%0d pos=%0d",
                 n_move, p0, a, md, (cp >= BIG) ? -1 : cp, glitch, npulse, p);
        n_move++;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pos_hold;
        zera_as_n = 1'b0; inicia = 1'b0; modo = 1'b0; para = 1'b0; alvo = '0;
        load = 1'b1; load_val = '0;
        repeat (2) @(posedge clock);
        #1;
        load = 1'b0;
        chk("reset_vai", vai, 0);
        chk("reset_vem", vem, 0);
        chk("reset_enable", enable_mov, 0);
        chk("reset_ocupado", ocupado, 0);
        chk("reset_pronto", pronto, 0);
        @(negedge clock); zera_as_n = 1'b1;
        dir_m = 1;
        @(posedge clock); #1;

        // Reset in the middle of a 10 -> 20 move: two pulses land before it.
        load = 1'b1; load_val = 7'd10;
        @(posedge clock); #1;
        load = 1'b0;
        inicia = 1'b1; alvo = 7'd20; modo = 1'b0;
        @(posedge clock); #1;
        inicia = 1'b0;
        repeat (11) @(posedge clock);
        #3;
        zera_as_n = 1'b0;
        #1;
        chk("midrst_ocupado", ocupado, 0);
        chk("midrst_enable", enable_mov, 0);
        chk("midrst_vai", vai | vem, 0);
        chk("midrst_pos", pos, 12);
        pos_hold = int'(pos);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk($sformatf("rst_hold_pulse[%0d]", i), vai | vem | pronto | ocupado, 0);
        end
        chk("rst_hold_pos", pos, pos_hold);
        zera_as_n = 1'b1;
        dir_m = 1;
        $display("[TB] reset mid-move: pos held at %0d", pos_hold);
        @(posedge clock); #1;

        run_move(10, 13, 0, BIG, 0);
        run_move(5, 2, 0, BIG, 0);
        run_move(97, 120, 0, BIG, 0);
        run_move(40, 40, 0, BIG, 0);
        // Sweep 97 -> 99 -> down; pos reaches 50 after 51 pulses (cycle 306).
        run_move(97, 0, 1, T + 2 + 50 * P, 0);
        chk("sweep_stop_pos", pos, 50);
        run_move(30, 35, 0, BIG, 8);

        // inicia together with para in idle must not start a move.
        inicia = 1'b1; para = 1'b1; alvo = 7'd60; modo = 1'b0;
        @(posedge clock); #1;
        inicia = 1'b0; para = 1'b0;
        @(negedge clock);
        chk("para_blocks_inicia", ocupado, 0);
        $display("[TB] inicia with para in idle: ocupado=%0d", ocupado);
        @(posedge clock); #1;

        for (int n = 0; n < 30; n++) begin
            int st, a, cp, gl;
            bit md;
            md = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 99));
            a  = $urandom_range(0, 127);
            if (md) cp = $urandom_range(1, 400);
            else cp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 200)) : BIG;
            gl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0;
            run_move(st, a, md, cp, gl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
